// File: rtl/ro_sweep_sequencer.sv
// Ring-oscillator sweep sequencer: for each enabled oscillator it clears the
// counters, gates a window, settles, captures and shifts out a framed count.
module ro_sweep_sequencer #(
  parameter int COUNTER_LENGTH = 20,
  parameter int NUM_ROS        = 3,
  parameter int WINDOW_BITS    = 16,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [WINDOW_BITS-1:0]    window_len,
  input  logic [NUM_ROS-1:0]        ro_mask,
  input  logic [COUNTER_LENGTH-1:0] cycle_count,
  output logic                      ctr_reset,
  output logic                      gate,
  output logic [1:0]                counter_select,
  output logic                      data_out,
  output logic                      data_valid,
  output logic                      frame_start,
  output logic                      busy,
  output logic                      done
);

  localparam int FW   = COUNTER_LENGTH + 6;
  localparam int CW_A = (WINDOW_BITS > $clog2(FW) + 1) ? WINDOW_BITS : $clog2(FW) + 1;
  localparam int CW   = (CW_A > $clog2(SETTLE_CYCLES) + 1) ? CW_A : $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, CAPTURE, SHIFT} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [WINDOW_BITS-1:0] win_q;
  logic [NUM_ROS-1:0]     mask_q;
  logic [FW-1:0]          shreg;
  logic [FW-1:0]          frame_w;
  logic [CW-1:0]          gate_load;
  logic [2:0]             nxt;

  function automatic logic [1:0] lowest(input logic [NUM_ROS-1:0] m);
    logic [1:0] r;
    r = '0;
    for (int i = NUM_ROS - 1; i >= 0; i--)
      if (m[i]) r = 2'(i);
    return r;
  endfunction

  // {found, index} of the lowest enabled oscillator above cur
  function automatic logic [2:0] next_above(input logic [NUM_ROS-1:0] m, input logic [1:0] cur);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_ROS - 1; i >= 0; i--)
      if (m[i] && i > int'(cur)) r = {1'b1, 2'(i)};
    return r;
  endfunction

  assign nxt       = next_above(mask_q, counter_select);
  assign frame_w   = {4'b1010, counter_select, cycle_count};
  assign gate_load = (win_q == '0) ? '0 : CW'(win_q - WINDOW_BITS'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      win_q          <= '0;
      mask_q         <= '0;
      shreg          <= '0;
      ctr_reset      <= 1'b0;
      gate           <= 1'b0;
      counter_select <= '0;
      data_out       <= 1'b0;
      data_valid     <= 1'b0;
      frame_start    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done        <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start && ro_mask != '0) begin
            win_q          <= window_len;
            mask_q         <= ro_mask;
            counter_select <= lowest(ro_mask);
            cnt            <= CW'(1);
            ctr_reset      <= 1'b1;
            busy           <= 1'b1;
            state          <= CLEAR;
          end
        end
        CLEAR: begin
          if (cnt == '0) begin
            ctr_reset <= 1'b0;
            gate      <= 1'b1;
            cnt       <= gate_load;
            state     <= GATE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GATE: begin
          if (cnt == '0) begin
            gate  <= 1'b0;
            cnt   <= CW'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= CAPTURE;
          else           cnt   <= cnt - CW'(1);
        end
        CAPTURE: begin
          data_out    <= frame_w[FW-1];
          shreg       <= {frame_w[FW-2:0], 1'b0};
          data_valid  <= 1'b1;
          frame_start <= 1'b1;
          cnt         <= CW'(FW - 1);
          state       <= SHIFT;
        end
        SHIFT: begin
          if (cnt == '0) begin
            data_valid <= 1'b0;
            data_out   <= 1'b0;
            if (nxt[2]) begin
              counter_select <= nxt[1:0];
              cnt            <= CW'(1);
              ctr_reset      <= 1'b1;
              state          <= CLEAR;
            end else begin
              done <= 1'b1;
              // continuous restart reloads the live inputs, like a fresh start
              if (continuous && ro_mask != '0) begin
                win_q          <= window_len;
                mask_q         <= ro_mask;
                counter_select <= lowest(ro_mask);
                cnt            <= CW'(1);
                ctr_reset      <= 1'b1;
                state          <= CLEAR;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end else begin
            data_out <= shreg[FW-1];
            shreg    <= {shreg[FW-2:0], 1'b0};
            cnt      <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_sweep_sequencer.sv
// Self-checking bench for ro_sweep_sequencer: table vectors, randomized sweeps
// against a frame/timing model, plus continuous, reset and start-while-busy sequences.
module tb_ro_sweep_sequencer;
  localparam int CL = 20, NR = 3, WB = 16, SC = 4, FW = CL + 6;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, continuous = 1'b0;
  logic [WB-1:0] window_len = '0;
  logic [NR-1:0] ro_mask = '0;
  logic [CL-1:0] cycle_count;
  logic          ctr_reset, gate, data_out, data_valid, frame_start, busy, done;
  logic [1:0]    counter_select;
  logic [CL-1:0] vals [4];

  ro_sweep_sequencer #(.COUNTER_LENGTH(CL), .NUM_ROS(NR), .WINDOW_BITS(WB), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .window_len(window_len), .ro_mask(ro_mask), .cycle_count(cycle_count),
    .ctr_reset(ctr_reset), .gate(gate), .counter_select(counter_select),
    .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign cycle_count = vals[counter_select];

  int total = 0, bad = 0;

  // observation state, sampled on the falling edge
  logic [FW-1:0] frames[$], exp_frames[$], cur;
  int            gates[$];
  int            bitcnt, glen, ndone, cyc, t_busy, lat;
  bit            rose, busy_prev, first_done_ctr, first_done_busy, last_done_busy;
  logic [3:0]    sel_seen;

  always @(negedge clk) begin
    cyc++;
    if (data_valid === 1'b1) begin
      if (frame_start) bitcnt = 0;
      cur = {cur[FW-2:0], data_out};
      bitcnt++;
      if (bitcnt == FW) frames.push_back(cur);
    end
    if (gate === 1'b1) glen++;
    else if (glen != 0) begin gates.push_back(glen); glen = 0; end
    if (busy === 1'b1) sel_seen[counter_select] = 1'b1;
    if (busy === 1'b1 && !busy_prev && !rose) begin rose = 1'b1; t_busy = cyc; end
    busy_prev = (busy === 1'b1);
    if (done === 1'b1) begin
      if (ndone == 0) begin first_done_ctr = ctr_reset; first_done_busy = busy; end
      ndone++;
      lat = cyc - t_busy;
      last_done_busy = busy;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_mon();
    frames.delete(); gates.delete();
    glen = 0; ndone = 0; rose = 1'b0; sel_seen = '0; lat = 0; bitcnt = 0;
    first_done_ctr = 1'b0; first_done_busy = 1'b0; last_done_busy = 1'b1;
  endtask

  // reference: one frame per enabled index, ascending, each {1010, idx, count}
  task automatic build_exp(input logic [2:0] m);
    exp_frames.delete();
    for (int i = 0; i < NR; i++)
      if (m[i]) exp_frames.push_back({4'b1010, 2'(i), vals[i]});
  endtask

  function automatic int model_lat(input logic [2:0] m, input logic [15:0] w);
    int wc = (w == 0) ? 1 : int'(w);
    return $countones(m) * (2 + wc + SC + 1 + CL + 6);
  endfunction

  task automatic wait_end(input string tag, input int budget);
    int k = 0;
    while (k < budget && !(ndone > 0 && busy == 1'b0)) begin tick(1); k++; end
    check({tag, ":finished"}, (k < budget), 1);
  endtask

  task automatic sweep(input logic [2:0] m, input logic [15:0] w, input bit scramble);
    ro_mask = m; window_len = w; clear_mon();
    start = 1'b1; tick(1); start = 1'b0;
    if (scramble) begin ro_mask = 3'($urandom_range(0, 7)); window_len = 16'($urandom_range(0, 100)); end
    if (m == 0) tick(30);
  endtask

  task automatic verify(input string tag, input logic [2:0] m, input int n, input int gw, input int elat);
    build_exp(m);
    check({tag, ":nframes"}, frames.size(), n);
    for (int i = 0; i < n && i < frames.size(); i++) check({tag, ":frame"}, frames[i], exp_frames[i]);
    check({tag, ":ngates"}, gates.size(), n);
    for (int i = 0; i < gates.size(); i++) check({tag, ":gatelen"}, gates[i], gw);
    check({tag, ":ndone"}, ndone, (n > 0) ? 1 : 0);
    check({tag, ":selects"}, sel_seen, {1'b0, m});
    if (n > 0) begin
      check({tag, ":latency"}, lat, elat);
      check({tag, ":done_busy"}, last_done_busy, 0);
    end else begin
      check({tag, ":no_busy"}, rose, 0);
    end
  endtask

  typedef struct { logic [2:0] mask; logic [15:0] win; int n; int gw; int lat; } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{3'b001, 16'd10, 1, 10, 43};
    tbl[1] = '{3'b101, 16'd3,  2, 3,  72};
    tbl[2] = '{3'b111, 16'd0,  3, 1,  102};
    tbl[3] = '{3'b010, 16'd1,  1, 1,  34};
    tbl[4] = '{3'b100, 16'd2,  1, 2,  35};
    tbl[5] = '{3'b000, 16'd5,  0, 0,  0};
    for (int i = 0; i < 4; i++) vals[i] = CL'($urandom);
    vals[0] = 20'hABCDE;
    clear_mon();

    tick(2);
    check("reset_outputs", {ctr_reset, gate, counter_select, data_out, data_valid, frame_start, busy, done}, 0);
    rst_n = 1'b1;
    tick(2);

    for (int t = 0; t < 6; t++) begin
      sweep(tbl[t].mask, tbl[t].win, 1'b0);
      if (tbl[t].n > 0) wait_end("table", 400);
      verify("table", tbl[t].mask, tbl[t].n, tbl[t].gw, tbl[t].lat);
      tick(3);
    end

    for (int r = 0; r < 10; r++) begin
      logic [2:0]  m;
      logic [15:0] w;
      m = 3'($urandom_range(1, 7));
      w = 16'($urandom_range(0, 12));
      for (int i = 0; i < 4; i++) vals[i] = CL'($urandom);
      sweep(m, w, 1'b1);
      wait_end("rand", 400);
      verify("rand", m, $countones(m), (w == 0) ? 1 : int'(w), model_lat(m, w));
      tick($urandom_range(1, 5));
    end

    // continuous mode: restart after sweep 1, drop continuous during sweep 2
    begin
      int k;
      ro_mask = 3'b011; window_len = 16'd2; continuous = 1'b1; clear_mon();
      start = 1'b1; tick(1); start = 1'b0;
      k = 0;
      while (k < 300 && ndone == 0) begin tick(1); k++; end
      check("cont:first_done_seen", ndone, 1);
      check("cont:done_with_ctr_reset", first_done_ctr, 1);
      check("cont:done_while_busy", first_done_busy, 1);
      tick(10); continuous = 1'b0;
      k = 0;
      while (k < 300 && busy == 1'b1) begin tick(1); k++; end
      check("cont:ndone", ndone, 2);
      check("cont:final_done_busy", last_done_busy, 0);
      check("cont:nframes", frames.size(), 4);
      build_exp(3'b011);
      for (int i = 0; i < frames.size() && i < 4; i++) check("cont:frame", frames[i], exp_frames[i % 2]);
      tick(10);
      check("cont:idle_after", busy, 0);
    end

    // start pulses while busy are ignored
    ro_mask = 3'b111; window_len = 16'd1; clear_mon();
    start = 1'b1; tick(1); start = 1'b0;
    tick(15); start = 1'b1; tick(1); start = 1'b0;
    tick(40); start = 1'b1; tick(1); start = 1'b0;
    wait_end("busy_start", 400);
    verify("busy_start", 3'b111, 3, 1, 102);
    tick(10);
    check("busy_start:stays_idle", busy, 0);

    // asynchronous reset while the gate is open
    begin
      int k;
      ro_mask = 3'b001; window_len = 16'd50; clear_mon();
      start = 1'b1; tick(1); start = 1'b0;
      k = 0;
      while (k < 20 && gate != 1'b1) begin tick(1); k++; end
      check("rst:gate_open", gate, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst:gate_async", gate, 0);
      check("rst:busy_async", busy, 0);
      check("rst:outputs_async", {ctr_reset, counter_select, data_valid, done}, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      check("rst:no_done", ndone, 0);
      sweep(3'b001, 16'd10, 1'b0);
      wait_end("rst_after", 400);
      verify("rst_after", 3'b001, 1, 10, 43);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
